// File: rtl/debug_slave_pkg.sv
// Shared encodings and default geometry for the JTAG debug slave command path.
package debug_slave_pkg;

    localparam int DEF_DATA_W      = 38;
    localparam int DEF_IR_W        = 2;
    localparam int DEF_ACT_BIT     = 35;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEPTH       = 4;

    typedef enum logic [1:0] {
        OCIMEM    = 2'd0,
        TRACECTRL = 2'd1,
        BREAK     = 2'd2,
        TRACEMEM  = 2'd3
    } debug_ir_e;

endpackage

// File: rtl/debug_slave_sync_edge.sv
// Brings an asynchronous TCK-domain level into clk and emits a one-cycle pulse on its rising edge.
module debug_slave_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic level_async,
    output logic rise_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic [SYNC_STAGES:0]   arm_q;

    // arm_q holds off detection until edge_q has reloaded from a full synchroniser,
    // so a level already high when reset is released never counts as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            arm_q  <= '0;
            rise_p <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], level_async};
            edge_q <= sync_q[SYNC_STAGES-1];
            arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
            rise_p <= arm_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~edge_q;
        end
    end

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// Sysclk-side debug slave front end: captures JTAG IR/DR updates into a small command FIFO
// and releases each command as a held jdo word plus a one-hot action/no-action strobe.
module debug_slave_cmd_queue
    import debug_slave_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int ACT_BIT     = DEF_ACT_BIT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     vs_uir,
    input  logic                     vs_udr,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [DATA_W-1:0]        sr,
    input  logic                     cmd_ready,
    input  logic                     clear_overrun,
    output logic                     cmd_valid,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [DATA_W-1:0]        jdo,
    output logic [2**IR_W-1:0]       take_action,
    output logic [2**IR_W-1:0]       take_no_action,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int NS = 2**IR_W;
    localparam int EW = IR_W + DATA_W;

    function automatic logic [NS-1:0] ir_onehot(input logic [IR_W-1:0] ir);
        ir_onehot     = '0;
        ir_onehot[ir] = 1'b1;
    endfunction

    logic uir_p, udr_p;

    debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .level_async (vs_uir),
        .rise_p      (uir_p)
    );

    debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .level_async (vs_udr),
        .rise_p      (udr_p)
    );

    logic [IR_W-1:0] ir_q;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [EW-1:0]   head;
    logic            full, pop, push, drop;

    // Pointers carry a wrap bit, so their difference is the occupancy 0..DEPTH.
    assign level     = wr_ptr - rd_ptr;
    assign cmd_valid = (wr_ptr != rd_ptr);
    assign full      = (level == (AW+1)'(DEPTH));
    assign pop       = cmd_valid & cmd_ready;
    assign push      = udr_p & (~full | pop);
    assign drop      = udr_p & full & ~pop;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign cmd_ir    = head[EW-1:DATA_W];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {ir_q, sr};
        end
    end

    // ir_q is written after the push reads it, so a same-cycle uir/udr pair uses the old IR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q           <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            overrun        <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (uir_p) begin
                ir_q <= ir_in;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                jdo    <= head[DATA_W-1:0];
                if (head[ACT_BIT]) begin
                    take_action <= ir_onehot(head[EW-1:DATA_W]);
                end else begin
                    take_no_action <= ir_onehot(head[EW-1:DATA_W]);
                end
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Randomised bench for debug_slave_cmd_queue with a queue-based reference model and directed corner cases.
module tb_debug_slave_cmd_queue;

    localparam int DATA_W  = 38;
    localparam int IR_W    = 2;
    localparam int ACT_BIT = 35;
    localparam int S       = 2;
    localparam int DEPTH   = 4;
    localparam int NS      = 4;
    localparam int EW      = IR_W + DATA_W;
    localparam int HL      = S + 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              vs_uir = 1'b0, vs_udr = 1'b0;
    logic [IR_W-1:0]   ir_in = '0;
    logic [DATA_W-1:0] sr = '0;
    logic              cmd_ready = 1'b0, clear_overrun = 1'b0;
    logic              cmd_valid, overrun;
    logic [IR_W-1:0]   cmd_ir;
    logic [DATA_W-1:0] jdo;
    logic [NS-1:0]     take_action, take_no_action;
    logic [2:0]        level;

    logic        p_vs_uir = 1'b0, p_vs_udr = 1'b0;
    logic [2:0]  p_ir_in = '0;
    logic [63:0] p_sr = '0;
    logic        p_cmd_ready = 1'b0;
    logic        p_cmd_valid, p_overrun;
    logic [2:0]  p_cmd_ir;
    logic [63:0] p_jdo;
    logic [7:0]  p_ta, p_tna;
    logic [3:0]  p_level;

    always #5 clk = ~clk;

    debug_slave_cmd_queue #(
        .DATA_W(DATA_W), .IR_W(IR_W), .ACT_BIT(ACT_BIT), .SYNC_STAGES(S), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
        .cmd_ready(cmd_ready), .clear_overrun(clear_overrun), .cmd_valid(cmd_valid), .cmd_ir(cmd_ir),
        .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action), .overrun(overrun),
        .level(level)
    );

    debug_slave_cmd_queue #(
        .DATA_W(64), .IR_W(3), .ACT_BIT(35), .SYNC_STAGES(3), .DEPTH(8)
    ) dut_wide (
        .clk(clk), .reset_n(reset_n), .vs_uir(p_vs_uir), .vs_udr(p_vs_udr), .ir_in(p_ir_in), .sr(p_sr),
        .cmd_ready(p_cmd_ready), .clear_overrun(1'b0), .cmd_valid(p_cmd_valid), .cmd_ir(p_cmd_ir),
        .jdo(p_jdo), .take_action(p_ta), .take_no_action(p_tna), .overrun(p_overrun), .level(p_level)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    bit rnd = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference model: an edge on a strobe input sampled at edge k takes effect at edge k+S+1,
    // the first sample after reset release never counts as an edge.
    logic [EW-1:0]     mq[$];
    logic [IR_W-1:0]   m_irq;
    logic [DATA_W-1:0] m_jdo;
    logic [NS-1:0]     m_ta, m_tna;
    bit                m_ovr;
    bit                hu [0:HL-1];
    bit                hi [0:HL-1];
    int                since;

    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            m_irq = '0; m_jdo = '0; m_ta = '0; m_tna = '0; m_ovr = 1'b0; since = 0;
            for (int i = 0; i < HL; i++) begin hu[i] = 1'b0; hi[i] = 1'b0; end
        end else begin
            bit udr_evt, uir_evt, drop;
            logic [EW-1:0] e;
            for (int i = HL-1; i > 0; i--) begin hu[i] = hu[i-1]; hi[i] = hi[i-1]; end
            hu[0] = vs_udr;
            hi[0] = vs_uir;
            since++;
            udr_evt = (since >= S+3) && hu[S+1] && !hu[S+2];
            uir_evt = (since >= S+3) && hi[S+1] && !hi[S+2];
            drop = 1'b0;
            m_ta = '0;
            m_tna = '0;
            if (mq.size() > 0 && cmd_ready) begin
                e = mq.pop_front();
                m_jdo = e[DATA_W-1:0];
                if (e[ACT_BIT]) m_ta[e[EW-1:DATA_W]] = 1'b1;
                else            m_tna[e[EW-1:DATA_W]] = 1'b1;
            end
            if (udr_evt) begin
                if (mq.size() < DEPTH) mq.push_back({m_irq, sr});
                else drop = 1'b1;
            end
            if (drop) m_ovr = 1'b1;
            else if (clear_overrun) m_ovr = 1'b0;
            if (uir_evt) m_irq = ir_in;
        end
    end

    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            chk("cmd_valid", 64'(cmd_valid), 64'(mq.size() != 0));
            chk("level", 64'(level), 64'(mq.size()));
            if (mq.size() != 0) chk("cmd_ir", 64'(cmd_ir), 64'(mq[0][EW-1:DATA_W]));
            chk("jdo", 64'(jdo), 64'(m_jdo));
            chk("take_action", 64'(take_action), 64'(m_ta));
            chk("take_no_action", 64'(take_no_action), 64'(m_tna));
            chk("overrun", 64'(overrun), 64'(m_ovr));
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rnd) begin
            cmd_ready = ($urandom_range(0, 2) != 0);
            clear_overrun = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic uir_pulse(input logic [IR_W-1:0] ir, input int hi_c, input int lo_c);
        ir_in = ir; vs_uir = 1'b1;
        repeat (hi_c) tick();
        vs_uir = 1'b0;
        repeat (lo_c) tick();
    endtask

    task automatic udr_pulse(input logic [DATA_W-1:0] d, input int hi_c, input int lo_c);
        sr = d; vs_udr = 1'b1;
        repeat (hi_c) tick();
        vs_udr = 1'b0;
        repeat (lo_c) tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        chk({tag, "_level"}, 64'(level), 64'd0);
        chk({tag, "_jdo"}, 64'(jdo), 64'd0);
        chk({tag, "_ta"}, 64'(take_action), 64'd0);
        chk({tag, "_tna"}, 64'(take_no_action), 64'd0);
        chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic [63:0] r;
        int w;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        chk_en = 1'b1;
        repeat (6) tick();

        // Wide instance: ir=7 with action bit set
        p_ir_in = 3'd7; p_vs_uir = 1'b1;
        repeat (6) tick();
        p_vs_uir = 1'b0;
        repeat (6) tick();
        p_sr = 64'hABCD_0008_0000_0001;
        p_cmd_ready = 1'b1;
        p_vs_udr = 1'b1;
        repeat (4) tick();
        chk("wide_valid_early", 64'(p_cmd_valid), 64'd0);
        tick();
        chk("wide_valid_e4", 64'(p_cmd_valid), 64'd1);
        chk("wide_ta_early", 64'(p_ta), 64'd0);
        tick();
        chk("wide_ta", 64'(p_ta), 64'h80);
        chk("wide_tna", 64'(p_tna), 64'd0);
        chk("wide_jdo", p_jdo, 64'hABCD_0008_0000_0001);
        chk("wide_valid_after", 64'(p_cmd_valid), 64'd0);
        tick();
        chk("wide_ta_gone", 64'(p_ta), 64'd0);
        p_vs_udr = 1'b0;
        repeat (6) tick();

        // Single action command on BREAK
        cmd_ready = 1'b1;
        uir_pulse(2'd2, 5, 5);
        sr = 38'h08_1234_5678; vs_udr = 1'b1;
        repeat (4) tick();
        chk("d1_ta_early", 64'(take_action), 64'd0);
        tick();
        chk("d1_ta", 64'(take_action), 64'b0100);
        chk("d1_tna", 64'(take_no_action), 64'd0);
        chk("d1_jdo", 64'(jdo), 64'h08_1234_5678);
        tick();
        chk("d1_ta_once", 64'(take_action), 64'd0);
        vs_udr = 1'b0;
        repeat (6) tick();

        // No-action command on OCIMEM
        uir_pulse(2'd0, 5, 5);
        sr = 38'h00_0000_00AB; vs_udr = 1'b1;
        w = 0;
        while (take_action == '0 && take_no_action == '0 && w < 20) begin tick(); w++; end
        chk("d2_strobe_seen", 64'(w < 20), 64'd1);
        chk("d2_tna", 64'(take_no_action), 64'b0001);
        chk("d2_ta", 64'(take_action), 64'd0);
        chk("d2_jdo", 64'(jdo), 64'h00_0000_00AB);
        vs_udr = 1'b0;
        repeat (6) tick();

        // Fill past capacity, then drain in order
        cmd_ready = 1'b0;
        uir_pulse(2'd1, 5, 5);
        for (int i = 0; i < 5; i++) begin
            d = (i % 2) ? DATA_W'(64'h8_0000_0100 + i) : DATA_W'(64'h200 + i);
            udr_pulse(d, 5, 5);
        end
        chk("d3_level_full", 64'(level), 64'd4);
        chk("d3_overrun", 64'(overrun), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cmd_ready = 1'b1; tick(); cmd_ready = 1'b0; tick();
            d = (i % 2) ? DATA_W'(64'h8_0000_0100 + i) : DATA_W'(64'h200 + i);
            chk("d3_drain_jdo", 64'(jdo), 64'(d));
        end
        chk("d3_level_empty", 64'(level), 64'd0);
        clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
        chk("d3_overrun_clr", 64'(overrun), 64'd0);

        // Push coinciding with pop while full
        for (int i = 0; i < 4; i++) udr_pulse(DATA_W'(64'h100 + i), 5, 5);
        chk("d4_level_pre", 64'(level), 64'd4);
        sr = 38'h3F_FFFF_FFFF; vs_udr = 1'b1;
        repeat (3) tick();
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0; tick();
        vs_udr = 1'b0;
        repeat (5) tick();
        chk("d4_level", 64'(level), 64'd4);
        chk("d4_overrun", 64'(overrun), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cmd_ready = 1'b1; tick(); cmd_ready = 1'b0; tick();
        end
        chk("d4_last_jdo", 64'(jdo), 64'h3F_FFFF_FFFF);

        // Reset mid-operation with vs_udr held high across release
        for (int i = 0; i < 3; i++) udr_pulse(DATA_W'(64'h40 + i), 5, 5);
        chk("d5_level3", 64'(level), 64'd3);
        sr = 38'h11_1111_1111; vs_udr = 1'b1;
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        check_all_zero("d5_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) tick();
        chk("d5_no_push", 64'(level), 64'd0);
        chk("d5_no_valid", 64'(cmd_valid), 64'd0);
        vs_udr = 1'b0;
        repeat (6) tick();

        // Randomised traffic
        rnd = 1'b1;
        for (int it = 0; it < 80; it++) begin
            int kind;
            kind = $urandom_range(0, 3);
            r = {$urandom(), $urandom()};
            if (kind == 0) begin
                uir_pulse(IR_W'($urandom_range(0, 3)), $urandom_range(4, 6), $urandom_range(4, 7));
            end else if (kind == 3) begin
                ir_in = IR_W'($urandom_range(0, 3)); sr = r[DATA_W-1:0];
                vs_uir = 1'b1; vs_udr = 1'b1;
                repeat ($urandom_range(4, 6)) tick();
                vs_uir = 1'b0; vs_udr = 1'b0;
                repeat ($urandom_range(4, 7)) tick();
            end else begin
                udr_pulse(r[DATA_W-1:0], $urandom_range(4, 6), $urandom_range(4, 7));
            end
        end
        rnd = 1'b0;
        clear_overrun = 1'b0;
        cmd_ready = 1'b1;
        repeat (20) tick();
        chk("final_empty", 64'(level), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
